axi3_slave_mem: RTL and testbench

Synthesizable AXI3 slave memory model that consumes the traffic produced by axi3_master_bfm.
- Terminates the AW/W/B and AR/R channels into an internal word-addressed RAM.
- Write path and read path are independent and run concurrently.
- Used as the default target for master BFM directed tests, and as a simple on-chip scratch memory.

---
 rtl/axi3_pkg.sv | 22 ++
 rtl/axi3_addr_gen.sv | 65 ++++++
 rtl/axi3_slave_mem.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi3_slave_mem.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - shared AXI3 burst, response and FSM state definitions
package axi3_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RSP_OKAY   = 2'd0;
  localparam logic [1:0] RSP_EXOKAY = 2'd1;
  localparam logic [1:0] RSP_SLVERR = 2'd2;
  localparam logic [1:0] RSP_DECERR = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi3_addr_gen.sv
// rtl/axi3_addr_gen.sv - next beat address, RAM word index and beat error check
module axi3_addr_gen
  import axi3_pkg::*;
#(
  parameter int          address_bus_width   = 32,
  parameter int          axi_len_width       = 4,
  parameter int          axi_size_width      = 3,
  parameter int          axi_brst_type_width = 3,
  parameter int          data_bus_width      = 32,
  parameter int          mem_depth_words     = 1024,
  parameter int unsigned base_addr           = 0,
  parameter int          idx_width           = $clog2(mem_depth_words)
) (
  input  logic [address_bus_width-1:0]   addr,
  input  logic [axi_len_width-1:0]       len,
  input  logic [axi_size_width-1:0]      size,
  input  logic [axi_brst_type_width-1:0] burst,
  output logic [address_bus_width-1:0]   next_addr,
  output logic [idx_width-1:0]           word_idx,
  output logic                           err
);

  localparam int            AW        = address_bus_width;
  localparam int            BW        = axi_brst_type_width;
  localparam int            LW        = axi_len_width;
  localparam int            BEAT_LOG2 = $clog2(data_bus_width / 8);
  localparam logic [AW-1:0] BASE      = AW'(base_addr);
  localparam logic [AW:0]   MEM_BYTES = (AW + 1)'(mem_depth_words) << BEAT_LOG2;

  logic [AW:0]   diff;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic          in_range;
  logic          size_err;
  logic          burst_err;
  logic          wrap_err;
  logic          is_incr;
  logic          is_wrap;

  // The extra top bit is the borrow: set when addr sits below base_addr.
  assign diff      = {1'b0, addr} - {1'b0, BASE};
  assign in_range  = !diff[AW] && ({1'b0, diff[AW-1:0]} < MEM_BYTES);
  assign word_idx  = idx_width'(diff[AW-1:0] >> BEAT_LOG2);

  assign is_incr   = (burst == BW'(INCR));
  assign is_wrap   = (burst == BW'(WRAP));
  assign incr_addr = addr + (AW'(1) << BEAT_LOG2);
  assign wrap_mask = ((AW'(len) + AW'(1)) << BEAT_LOG2) - AW'(1);

  assign size_err  = (size != axi_size_width'(BEAT_LOG2));
  assign burst_err = (burst > BW'(WRAP));
  assign wrap_err  = is_wrap && !((len == LW'(1)) || (len == LW'(3)) ||
                                  (len == LW'(7)) || (len == LW'(15)));
  assign err       = !in_range || size_err || burst_err || wrap_err;

  always_comb begin
    next_addr = addr;
    if (is_incr) begin
      next_addr = incr_addr;
    end else if (is_wrap) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi3_slave_mem.sv
// rtl/axi3_slave_mem.sv - AXI3 slave terminating AW/W/B and AR/R into a word RAM
module axi3_slave_mem
  import axi3_pkg::*;
#(
  parameter int          data_bus_width      = 32,
  parameter int          address_bus_width   = 32,
  parameter int          id_bus_width        = 3,
  parameter int          axi_len_width       = 4,
  parameter int          axi_size_width      = 3,
  parameter int          axi_lock_width      = 2,
  parameter int          axi_prot_width      = 3,
  parameter int          axi_cache_width     = 4,
  parameter int          axi_brst_type_width = 3,
  parameter int          axi_rsp_width       = 2,
  parameter int          mem_depth_words     = 1024,
  parameter int unsigned base_addr           = 0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [id_bus_width-1:0]        AWID,
  input  logic [address_bus_width-1:0]   AWADDR,
  input  logic [axi_len_width-1:0]       AWLEN,
  input  logic [axi_size_width-1:0]      AWSIZE,
  input  logic [axi_brst_type_width-1:0] AWBURST,
  input  logic [axi_lock_width-1:0]      AWLOCK,
  input  logic [axi_cache_width-1:0]     AWCACHE,
  input  logic [axi_prot_width-1:0]      AWPROT,
  input  logic [3:0]                     AWQOS,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [id_bus_width-1:0]        WID,
  input  logic [data_bus_width-1:0]      WDATA,
  input  logic [data_bus_width/8-1:0]    WSTRB,
  input  logic                           WLAST,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [id_bus_width-1:0]        BID,
  output logic [axi_rsp_width-1:0]       BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [id_bus_width-1:0]        ARID,
  input  logic [address_bus_width-1:0]   ARADDR,
  input  logic [axi_len_width-1:0]       ARLEN,
  input  logic [axi_size_width-1:0]      ARSIZE,
  input  logic [axi_brst_type_width-1:0] ARBURST,
  input  logic [axi_lock_width-1:0]      ARLOCK,
  input  logic [axi_cache_width-1:0]     ARCACHE,
  input  logic [axi_prot_width-1:0]      ARPROT,
  input  logic [3:0]                     ARQOS,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [id_bus_width-1:0]        RID,
  output logic [data_bus_width-1:0]      RDATA,
  output logic [axi_rsp_width-1:0]       RRESP,
  output logic                           RLAST
);

  localparam int STRB_W = data_bus_width / 8;
  localparam int IDX_W  = $clog2(mem_depth_words);
  localparam int AW     = address_bus_width;
  localparam int LW     = axi_len_width;
  localparam logic [axi_rsp_width-1:0] OKAY   = axi_rsp_width'(RSP_OKAY);
  localparam logic [axi_rsp_width-1:0] SLVERR = axi_rsp_width'(RSP_SLVERR);

  logic [data_bus_width-1:0] mem [mem_depth_words];

  logic unused_sideband;
  assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, WID,
                             ARLOCK, ARCACHE, ARPROT, ARQOS};

  // ---------------- write path ----------------
  logic [1:0]                     w_state;
  logic                           aw_ready;
  logic                           w_err;
  logic [id_bus_width-1:0]        aw_id;
  logic [AW-1:0]                  w_addr;
  logic [LW-1:0]                  aw_len;
  logic [LW-1:0]                  w_cnt;
  logic [axi_size_width-1:0]      aw_size;
  logic [axi_brst_type_width-1:0] aw_burst;
  logic [AW-1:0]                  w_next;
  logic [IDX_W-1:0]               w_word;
  logic                           w_gen_err;
  logic                           aw_hs;
  logic                           w_hs;
  logic                           w_beat_err;
  logic                           w_we;

  assign AWREADY = aw_ready;
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BID     = aw_id;
  assign BRESP   = (BVALID && w_err) ? SLVERR : OKAY;

  assign aw_hs      = AWVALID && aw_ready;
  assign w_hs       = WVALID && WREADY;
  // WLAST is expected exactly on the beat whose counter has reached zero.
  assign w_beat_err = w_gen_err || (WLAST != (w_cnt == '0));
  assign w_we       = w_hs && !w_beat_err;

  axi3_addr_gen #(
    .address_bus_width  (address_bus_width),
    .axi_len_width      (axi_len_width),
    .axi_size_width     (axi_size_width),
    .axi_brst_type_width(axi_brst_type_width),
    .data_bus_width     (data_bus_width),
    .mem_depth_words    (mem_depth_words),
    .base_addr          (base_addr),
    .idx_width          (IDX_W)
  ) u_wgen (
    .addr     (w_addr),
    .len      (aw_len),
    .size     (aw_size),
    .burst    (aw_burst),
    .next_addr(w_next),
    .word_idx (w_word),
    .err      (w_gen_err)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_err    <= 1'b0;
      aw_id    <= '0;
      w_addr   <= '0;
      aw_len   <= '0;
      w_cnt    <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready <= !aw_hs;
          if (aw_hs) begin
            aw_id    <= AWID;
            w_addr   <= AWADDR;
            aw_len   <= AWLEN;
            w_cnt    <= AWLEN;
            aw_size  <= AWSIZE;
            aw_burst <= AWBURST;
            w_err    <= 1'b0;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt - LW'(1);
            if (w_beat_err) begin
              w_err <= 1'b1;
            end
            if (w_cnt == '0) begin
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) begin
          mem[w_word][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]                     r_state;
  logic                           ar_ready;
  logic                           r_last;
  logic [id_bus_width-1:0]        r_id;
  logic [AW-1:0]                  r_addr;
  logic [LW-1:0]                  r_len;
  logic [LW-1:0]                  r_cnt;
  logic [axi_size_width-1:0]      r_size;
  logic [axi_brst_type_width-1:0] r_burst;
  logic [data_bus_width-1:0]      r_data;
  logic [axi_rsp_width-1:0]       r_resp;
  logic                           r_idle;
  logic                           ar_hs;
  logic [AW-1:0]                  g_addr;
  logic [LW-1:0]                  g_len;
  logic [axi_size_width-1:0]      g_size;
  logic [axi_brst_type_width-1:0] g_burst;
  logic [AW-1:0]                  r_next;
  logic [IDX_W-1:0]               r_word;
  logic                           r_gen_err;

  assign ARREADY = ar_ready;
  assign RVALID  = (r_state == R_DATA);
  assign RID     = r_id;
  assign RDATA   = r_data;
  assign RRESP   = r_resp;
  assign RLAST   = r_last;

  assign r_idle = (r_state == R_IDLE);
  assign ar_hs  = ARVALID && ar_ready;

  // r_addr holds the address of the beat to load next, so a single generator
  // serves both the AR capture (port fields) and every later beat.
  assign g_addr  = r_idle ? ARADDR  : r_addr;
  assign g_len   = r_idle ? ARLEN   : r_len;
  assign g_size  = r_idle ? ARSIZE  : r_size;
  assign g_burst = r_idle ? ARBURST : r_burst;

  axi3_addr_gen #(
    .address_bus_width  (address_bus_width),
    .axi_len_width      (axi_len_width),
    .axi_size_width     (axi_size_width),
    .axi_brst_type_width(axi_brst_type_width),
    .data_bus_width     (data_bus_width),
    .mem_depth_words    (mem_depth_words),
    .base_addr          (base_addr),
    .idx_width          (IDX_W)
  ) u_rgen (
    .addr     (g_addr),
    .len      (g_len),
    .size     (g_size),
    .burst    (g_burst),
    .next_addr(r_next),
    .word_idx (r_word),
    .err      (r_gen_err)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_data   <= '0;
      r_resp   <= '0;
    end else if (r_idle) begin
      ar_ready <= !ar_hs;
      if (ar_hs) begin
        r_id    <= ARID;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_cnt   <= ARLEN;
        r_last  <= (ARLEN == '0);
        r_addr  <= r_next;
        r_data  <= r_gen_err ? '0 : mem[r_word];
        r_resp  <= r_gen_err ? SLVERR : OKAY;
        r_state <= R_DATA;
      end
    end else if (RREADY) begin
      if (r_last) begin
        r_last   <= 1'b0;
        ar_ready <= 1'b1;
        r_state  <= R_IDLE;
      end else begin
        r_cnt  <= r_cnt - LW'(1);
        r_last <= (r_cnt == LW'(1));
        r_addr <= r_next;
        r_data <= r_gen_err ? '0 : mem[r_word];
        r_resp <= r_gen_err ? SLVERR : OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi3_slave_mem.sv
// tb/tb_axi3_slave_mem.sv - directed self-checking bench for axi3_slave_mem
module tb_axi3_slave_mem;

  localparam int TMO = 50;

  logic        ACLK;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [2:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE, AWBURST;
  logic [1:0]  AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWQOS;
  logic        WVALID, WREADY;
  logic [2:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [2:0]  BID;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [2:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE, ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [3:0]  ARQOS;
  logic        RVALID, RREADY;
  logic [2:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;

  int          n_tests;
  int          n_fail;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic        rl [16];
  logic [1:0]  rr [16];
  logic [2:0]  rid_got;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  int          rd_gaps;

  axi3_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK),
    .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
    .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
    .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic timeout(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s timeout: no handshake within %0d cycles", what, TMO);
  endtask

  // Helpers start and end on a falling edge; handshakes complete on the rising edge between.
  task automatic wr_burst(input logic [2:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [2:0] burst,
                          input logic [3:0] strb, input int last_at);
    int n;
    AWVALID = 1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    n = 0;
    while (!AWREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n >= TMO) timeout("aw");
    @(negedge ACLK);
    AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1; WDATA = wd[i]; WSTRB = strb; WLAST = (i == last_at);
      n = 0;
      while (!WREADY && n < TMO) begin @(negedge ACLK); n++; end
      if (n >= TMO) begin timeout("w"); break; end
      @(negedge ACLK);
    end
    WVALID = 0; WLAST = 0; BREADY = 1;
    n = 0;
    while (!BVALID && n < TMO) begin @(negedge ACLK); n++; end
    if (n >= TMO) timeout("b");
    b_resp = BRESP; b_id = BID;
    @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic send_ar(input logic [2:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [2:0] burst);
    int n;
    ARVALID = 1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    n = 0;
    while (!ARREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n >= TMO) timeout("ar");
    @(negedge ACLK);
    ARVALID = 0;
  endtask

  task automatic rd_burst(input logic [2:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [2:0] burst);
    int n;
    send_ar(id, addr, len, size, burst);
    RREADY = 1;
    rd_gaps = 0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < TMO) begin @(negedge ACLK); n++; end
      if (n >= TMO) begin timeout("r"); break; end
      rd_gaps += n;
      rd[i] = RDATA; rl[i] = RLAST; rr[i] = RRESP; rid_got = RID;
      @(negedge ACLK);
    end
    RREADY = 0;
  endtask

  task automatic test_reset();
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    n_tests++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST});
    end
    ARESETn = 1;
    n_tests++;
    if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge got aw=%b ar=%b want 0 0", AWREADY, ARREADY);
    end
    @(negedge ACLK);
    n_tests++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got aw=%b ar=%b want 1 1", AWREADY, ARREADY);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    wr_burst(3'd5, 32'h10, 4'd3, 3'd2, 3'd1, 4'hF, 3);
    n_tests++;
    if (b_resp !== 2'd0 || b_id !== 3'd5) begin
      n_fail++;
      $display("FAIL incr_wr_b got resp=%0d id=%0d want 0 5", b_resp, b_id);
    end
    rd_burst(3'd2, 32'h10, 4'd3, 3'd2, 3'd1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd[i] !== 32'hA0 + 32'(i) || rl[i] !== (i == 3) || rr[i] !== 2'd0) begin
        n_fail++;
        $display("FAIL incr_rd beat %0d got data=%h last=%b resp=%0d want %h %b 0",
                 i, rd[i], rl[i], rr[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
    n_tests++;
    if (rid_got !== 3'd2 || rd_gaps !== 0) begin
      n_fail++;
      $display("FAIL incr_rd_id_gaps got id=%0d gaps=%0d want 2 0", rid_got, rd_gaps);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA2; exp_d[1] = 32'hA3; exp_d[2] = 32'hA0; exp_d[3] = 32'hA1;
    rd_burst(3'd1, 32'h18, 4'd3, 3'd2, 3'd2);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd[i] !== exp_d[i] || rr[i] !== 2'd0) begin
        n_fail++;
        $display("FAIL wrap_rd beat %0d got %h resp=%0d want %h 0", i, rd[i], rr[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_strobe();
    wd[0] = 32'h12345678;
    wr_burst(3'd0, 32'h40, 4'd0, 3'd2, 3'd1, 4'hF, 0);
    wd[0] = 32'hFFFFFFFF;
    wr_burst(3'd0, 32'h40, 4'd0, 3'd2, 3'd1, 4'h3, 0);
    rd_burst(3'd0, 32'h40, 4'd0, 3'd2, 3'd1);
    n_tests++;
    if (rd[0] !== 32'h1234FFFF || b_resp !== 2'd0) begin
      n_fail++;
      $display("FAIL strobe got %h bresp=%0d want 1234ffff 0", rd[0], b_resp);
    end
  endtask

  task automatic test_errors();
    wd[0] = 32'hCAFE0000;
    wr_burst(3'd0, 32'h0, 4'd0, 3'd2, 3'd1, 4'hF, 0);
    wd[0] = 32'hDEADBEEF;
    wr_burst(3'd4, 32'h1000, 4'd0, 3'd2, 3'd1, 4'hF, 0);
    n_tests++;
    if (b_resp !== 2'd2) begin n_fail++; $display("FAIL oob_wr_bresp got %0d want 2", b_resp); end
    rd_burst(3'd0, 32'h0, 4'd0, 3'd2, 3'd1);
    n_tests++;
    if (rd[0] !== 32'hCAFE0000) begin n_fail++; $display("FAIL oob_ram_kept got %h want cafe0000", rd[0]); end
    rd_burst(3'd0, 32'h1000, 4'd0, 3'd2, 3'd1);
    n_tests++;
    if (rd[0] !== 32'h0 || rr[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL oob_rd got %h resp=%0d want 0 2", rd[0], rr[0]);
    end
    for (int i = 0; i < 4; i++) wd[i] = 32'h55 + 32'(i);
    wr_burst(3'd3, 32'h80, 4'd3, 3'd2, 3'd1, 4'hF, 1);
    n_tests++;
    if (b_resp !== 2'd2 || b_id !== 3'd3) begin
      n_fail++;
      $display("FAIL early_wlast got resp=%0d id=%0d want 2 3", b_resp, b_id);
    end
    wr_burst(3'd0, 32'h90, 4'd1, 3'd2, 3'd1, 4'hF, -1);
    n_tests++;
    if (b_resp !== 2'd2) begin n_fail++; $display("FAIL missing_wlast got %0d want 2", b_resp); end
    wr_burst(3'd0, 32'hA0, 4'd0, 3'd1, 3'd1, 4'hF, 0);
    n_tests++;
    if (b_resp !== 2'd2) begin n_fail++; $display("FAIL bad_size got %0d want 2", b_resp); end
    rd_burst(3'd0, 32'h10, 4'd1, 3'd2, 3'd3);
    n_tests++;
    if (rr[0] !== 2'd2 || rr[1] !== 2'd2 || rd[0] !== 32'h0 || rd[1] !== 32'h0 || rl[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_burst got resp=%0d,%0d data=%h,%h last=%b want 2,2 0,0 1",
               rr[0], rr[1], rd[0], rd[1], rl[1]);
    end
    rd_burst(3'd0, 32'h10, 4'd2, 3'd2, 3'd2);
    n_tests++;
    if (rr[0] !== 2'd2 || rr[2] !== 2'd2) begin
      n_fail++;
      $display("FAIL bad_wrap_len got resp=%0d,%0d want 2,2", rr[0], rr[2]);
    end
    wd[0] = 32'h77;
    wr_burst(3'd0, 32'hB0, 4'd0, 3'd2, 3'd1, 4'hF, 0);
    n_tests++;
    if (b_resp !== 2'd0) begin n_fail++; $display("FAIL err_not_sticky got %0d want 0", b_resp); end
  endtask

  task automatic test_stall();
    int n;
    for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
    wr_burst(3'd0, 32'h200, 4'd3, 3'd2, 3'd1, 4'hF, 3);
    send_ar(3'd6, 32'h200, 4'd3, 3'd2, 3'd1);
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (RVALID !== 1'b1 || RDATA !== 32'hB1 || RLAST !== 1'b0 || RID !== 3'd6) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got v=%b d=%h l=%b id=%0d want 1 b1 0 6",
                 c, RVALID, RDATA, RLAST, RID);
      end
      @(negedge ACLK);
    end
    RREADY = 1;
    for (int i = 1; i < 4; i++) begin
      n = 0;
      while (!RVALID && n < TMO) begin @(negedge ACLK); n++; end
      if (n >= TMO) begin timeout("stall_r"); break; end
      rd[i] = RDATA; rl[i] = RLAST;
      @(negedge ACLK);
    end
    RREADY = 0;
    n_tests++;
    if (rd[2] !== 32'hB2 || rd[3] !== 32'hB3 || rl[2] !== 1'b0 || rl[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_tail got %h %h last=%b%b want b2 b3 01", rd[2], rd[3], rl[2], rl[3]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
    fork
      wr_burst(3'd7, 32'h300, 4'd3, 3'd2, 3'd1, 4'hF, 3);
      rd_burst(3'd4, 32'h10, 4'd3, 3'd2, 3'd1);
    join
    n_tests++;
    if (b_resp !== 2'd0 || b_id !== 3'd7 || rd[0] !== 32'hA0 || rd[3] !== 32'hA3 || rd_gaps !== 0) begin
      n_fail++;
      $display("FAIL concurrent got bresp=%0d bid=%0d rd0=%h rd3=%h gaps=%0d want 0 7 a0 a3 0",
               b_resp, b_id, rd[0], rd[3], rd_gaps);
    end
    rd_burst(3'd0, 32'h300, 4'd3, 3'd2, 3'd1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd[i] !== 32'hC0 + 32'(i)) begin
        n_fail++;
        $display("FAIL concurrent_wr beat %0d got %h want %h", i, rd[i], 32'hC0 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    send_ar(3'd1, 32'h200, 4'd3, 3'd2, 3'd1);
    RREADY = 1;
    @(negedge ACLK);
    #2 ARESETn = 0;
    #1;
    n_tests++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b l=%b d=%h arready=%b want 0 0 0 0",
               RVALID, RLAST, RDATA, ARREADY);
    end
    @(negedge ACLK);
    RREADY = 0;
    ARESETn = 1;
    @(negedge ACLK);
    n_tests++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got arready=%b rvalid=%b want 1 0", ARREADY, RVALID);
    end
    rd_burst(3'd2, 32'h10, 4'd0, 3'd2, 3'd1);
    n_tests++;
    if (rd[0] !== 32'hA0 || rl[0] !== 1'b1 || rr[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_read got %h last=%b resp=%0d want a0 1 0", rd[0], rl[0], rr[0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ARESETn = 0;
    AWVALID = 0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWLOCK = '0; AWCACHE = '0; AWPROT = '0; AWQOS = '0;
    WVALID = 0; WID = '0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARLOCK = '0; ARCACHE = '0; ARPROT = '0; ARQOS = '0; RREADY = 0;
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
